// File: rtl/hdmi_tmds_pkg.sv
// Shared constants and helpers for the HDMI TMDS lane encoder.
package hdmi_tmds_pkg;

    typedef enum logic [2:0] {
        MODE_CTRL         = 3'd0,
        MODE_VIDEO        = 3'd1,
        MODE_VIDEO_GUARD  = 3'd2,
        MODE_ISLAND_GUARD = 3'd3,
        MODE_ISLAND       = 3'd4
    } mode_t;

    typedef enum logic [2:0] {
        S_CTRL,
        S_VG1,
        S_VG2,
        S_VIDEO,
        S_IG_LEAD1,
        S_IG_LEAD2,
        S_ISLAND,
        S_IG_TRAIL1
    } seq_state_t;

    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    localparam logic [9:0] VGUARD_LANE02 = 10'b1011001100;
    localparam logic [9:0] VGUARD_LANE1  = 10'b0100110011;
    localparam logic [9:0] IGUARD_LANE12 = 10'b0100110011;

    function automatic logic [9:0] ctrl_encode(input logic v, input logic h);
        case ({v, h})
            2'b00:   return CTRL_00;
            2'b01:   return CTRL_01;
            2'b10:   return CTRL_10;
            default: return CTRL_11;
        endcase
    endfunction

    function automatic logic [9:0] terc4_encode(input logic [3:0] nib);
        case (nib)
            4'h0: return 10'b1010011100;
            4'h1: return 10'b1001100011;
            4'h2: return 10'b1011100100;
            4'h3: return 10'b1011100010;
            4'h4: return 10'b0101110001;
            4'h5: return 10'b0100011110;
            4'h6: return 10'b0110001110;
            4'h7: return 10'b0100111100;
            4'h8: return 10'b1011001100;
            4'h9: return 10'b0100111001;
            4'hA: return 10'b0110011100;
            4'hB: return 10'b1011000110;
            4'hC: return 10'b1010001110;
            4'hD: return 10'b1001110001;
            4'hE: return 10'b0101100011;
            default: return 10'b1011000011;
        endcase
    endfunction

    function automatic logic [3:0] n1_count(input logic [7:0] v);
        logic [3:0] acc;
        acc = '0;
        for (int unsigned i = 0; i < 8; i++)
            acc = acc + {3'b000, v[i]};
        return acc;
    endfunction

    function automatic logic [3:0] n0_count(input logic [7:0] v);
        return 4'd8 - n1_count(v);
    endfunction

endpackage

// File: rtl/hdmi_tmds_encoder_seq_check.sv
// Guard-band / period sequencing checker with a sticky error flag.
module hdmi_tmds_seq_check (
    input  logic       clk,
    input  logic       reset_low,
    input  logic [2:0] mode,
    input  logic       err_clear,
    output logic       mode_error
);
    import hdmi_tmds_pkg::*;

    seq_state_t state;
    seq_state_t state_next;
    logic       err;

    // State register
    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) state <= S_CTRL;
        else            state <= state_next;
    end

    // Legal-transition table; anything unlisted is an error and returns to S_CTRL
    always_comb begin
        state_next = S_CTRL;
        err        = 1'b0;
        case (state)
            S_CTRL: begin
                if (mode == MODE_CTRL)              state_next = S_CTRL;
                else if (mode == MODE_VIDEO_GUARD)  state_next = S_VG1;
                else if (mode == MODE_ISLAND_GUARD) state_next = S_IG_LEAD1;
                else                                err = 1'b1;
            end
            S_VG1: begin
                if (mode == MODE_VIDEO_GUARD) state_next = S_VG2;
                else                          err = 1'b1;
            end
            S_VG2: begin
                if (mode == MODE_VIDEO) state_next = S_VIDEO;
                else                    err = 1'b1;
            end
            S_VIDEO: begin
                if (mode == MODE_VIDEO)     state_next = S_VIDEO;
                else if (mode == MODE_CTRL) state_next = S_CTRL;
                else                        err = 1'b1;
            end
            S_IG_LEAD1: begin
                if (mode == MODE_ISLAND_GUARD) state_next = S_IG_LEAD2;
                else                           err = 1'b1;
            end
            S_IG_LEAD2: begin
                if (mode == MODE_ISLAND) state_next = S_ISLAND;
                else                     err = 1'b1;
            end
            S_ISLAND: begin
                if (mode == MODE_ISLAND)            state_next = S_ISLAND;
                else if (mode == MODE_ISLAND_GUARD) state_next = S_IG_TRAIL1;
                else                                err = 1'b1;
            end
            S_IG_TRAIL1: begin
                if (mode == MODE_ISLAND_GUARD) state_next = S_CTRL;
                else                           err = 1'b1;
            end
            default: err = 1'b1;
        endcase
    end

    // Sticky flag: a new error in the same cycle as err_clear keeps it set
    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low)     mode_error <= 1'b0;
        else if (err)       mode_error <= 1'b1;
        else if (err_clear) mode_error <= 1'b0;
    end

endmodule

// File: rtl/hdmi_tmds_encoder.sv
// One TMDS lane: transition minimising, DC balancing, control/guard/TERC4
// symbol selection and a retiming output pipeline.
module hdmi_tmds_encoder #(
    parameter int unsigned CHANNEL    = 0,
    parameter int unsigned OUT_STAGES = 2,
    parameter int unsigned CNT_WIDTH  = 6
) (
    input  logic                        clk,
    input  logic                        reset_low,
    input  logic [2:0]                  mode,
    input  logic                        h_sync,
    input  logic                        v_sync,
    input  logic [7:0]                  data_in,
    input  logic [3:0]                  aux_in,
    input  logic                        err_clear,
    output logic [9:0]                  data_out,
    output logic signed [CNT_WIDTH-1:0] disparity,
    output logic                        mode_error
);
    import hdmi_tmds_pkg::*;

    localparam logic signed [CNT_WIDTH-1:0] TWO = CNT_WIDTH'(2);

    // Stage-1 signals
    logic [3:0] d_ones;
    logic       use_xnor;
    logic [8:0] qm_next;
    logic [2:0] s1_mode;
    logic       s1_vsync;
    logic       s1_hsync;
    logic [3:0] s1_aux;
    logic [8:0] s1_qm;

    // Stage-2 signals
    logic [3:0]                  qm_ones;
    logic [3:0]                  qm_zeros;
    logic signed [CNT_WIDTH-1:0] ones_s;
    logic signed [CNT_WIDTH-1:0] zeros_s;
    logic signed [CNT_WIDTH-1:0] cnt;
    logic signed [CNT_WIDTH-1:0] cnt_next;
    logic                        cnt_pos;
    logic                        cnt_neg;
    logic [3:0]                  island_nib;
    logic [9:0]                  sym_next;
    logic [9:0]                  pipe [0:OUT_STAGES];

    // Transition-minimising XOR/XNOR chain
    always_comb begin
        d_ones     = n1_count(data_in);
        use_xnor   = (d_ones > 4'd4) || ((d_ones == 4'd4) && !data_in[0]);
        qm_next    = '0;
        qm_next[0] = data_in[0];
        for (int unsigned i = 1; i < 8; i++)
            qm_next[i] = use_xnor ? ~(qm_next[i-1] ^ data_in[i]) : (qm_next[i-1] ^ data_in[i]);
        qm_next[8] = ~use_xnor;
    end

    // Stage-1 register; reset state decodes as control code 00
    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            s1_mode  <= MODE_CTRL;
            s1_vsync <= 1'b0;
            s1_hsync <= 1'b0;
            s1_aux   <= '0;
            s1_qm    <= '0;
        end else begin
            s1_mode  <= mode;
            s1_vsync <= v_sync;
            s1_hsync <= h_sync;
            s1_aux   <= aux_in;
            s1_qm    <= qm_next;
        end
    end

    // DC balancing and symbol select
    always_comb begin
        qm_ones    = n1_count(s1_qm[7:0]);
        qm_zeros   = n0_count(s1_qm[7:0]);
        ones_s     = CNT_WIDTH'(qm_ones);
        zeros_s    = CNT_WIDTH'(qm_zeros);
        cnt_neg    = cnt[CNT_WIDTH-1];
        cnt_pos    = !cnt[CNT_WIDTH-1] && (cnt != '0);
        // Lane 0 carries the syncs in the low two TERC4 bits during islands
        island_nib = (CHANNEL == 0) ? {s1_aux[3:2], s1_vsync, s1_hsync} : s1_aux;
        sym_next   = ctrl_encode(s1_vsync, s1_hsync);
        cnt_next   = '0;
        case (s1_mode)
            MODE_VIDEO: begin
                if ((cnt == '0) || (qm_ones == qm_zeros)) begin
                    sym_next = {~s1_qm[8], s1_qm[8], s1_qm[8] ? s1_qm[7:0] : ~s1_qm[7:0]};
                    cnt_next = s1_qm[8] ? (cnt + ones_s - zeros_s) : (cnt + zeros_s - ones_s);
                end else if ((cnt_pos && (qm_ones > qm_zeros)) || (cnt_neg && (qm_zeros > qm_ones))) begin
                    sym_next = {1'b1, s1_qm[8], ~s1_qm[7:0]};
                    cnt_next = cnt + (s1_qm[8] ? TWO : '0) + zeros_s - ones_s;
                end else begin
                    sym_next = {1'b0, s1_qm[8], s1_qm[7:0]};
                    cnt_next = cnt + ones_s - zeros_s - (s1_qm[8] ? '0 : TWO);
                end
            end
            MODE_VIDEO_GUARD: begin
                sym_next = (CHANNEL == 1) ? VGUARD_LANE1 : VGUARD_LANE02;
            end
            MODE_ISLAND_GUARD: begin
                sym_next = (CHANNEL == 0) ? terc4_encode({2'b11, s1_vsync, s1_hsync}) : IGUARD_LANE12;
            end
            MODE_ISLAND: begin
                sym_next = terc4_encode(island_nib);
            end
            default: ;
        endcase
    end

    // Stage-2 register plus OUT_STAGES retiming flops
    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            for (int unsigned i = 0; i <= OUT_STAGES; i++)
                pipe[i] <= CTRL_00;
            cnt <= '0;
        end else begin
            pipe[0] <= sym_next;
            for (int unsigned i = 1; i <= OUT_STAGES; i++)
                pipe[i] <= pipe[i-1];
            cnt <= cnt_next;
        end
    end

    assign data_out  = pipe[OUT_STAGES];
    assign disparity = cnt;

    hdmi_tmds_seq_check u_seq_check (
        .clk        (clk),
        .reset_low  (reset_low),
        .mode       (s1_mode),
        .err_clear  (err_clear),
        .mode_error (mode_error)
    );

endmodule
